// File: rtl/instr_ctrl.sv
// Multi-cycle instruction control FSM for the register-file/ALU datapath.
// Sequence: FETCH -> DECODE -> EXEC -> (MEM) -> WB -> FETCH.
// Every control output is driven from a register, so nothing on mem_ack or
// psr_in reaches an output combinationally.
module instr_ctrl #(
    parameter int DATAW  = 16,
    parameter int REGW   = 4,
    parameter int ALUOPW = 4,
    parameter int IMMW   = 8,
    parameter int PSRW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATAW-1:0]  instr,
    input  logic [PSRW-1:0]   psr_in,
    input  logic              mem_ack,
    output logic              write,
    output logic              IMM_MUX,
    output logic              COND_RSLT,
    output logic              WB_MUX0,
    output logic [1:0]        WB_MUX,
    output logic [REGW-1:0]   rSrc,
    output logic [REGW-1:0]   rDst,
    output logic [ALUOPW-1:0] aluOp,
    output logic [IMMW-1:0]   imm_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic              pc_inc,
    output logic              pc_load
);

    // FSM encoding
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    // Instruction classes
    localparam logic [3:0] CL_ALU_REG = 4'd0;
    localparam logic [3:0] CL_ALU_IMM = 4'd1;
    localparam logic [3:0] CL_LOAD    = 4'd2;
    localparam logic [3:0] CL_STOR    = 4'd3;
    localparam logic [3:0] CL_JAL     = 4'd4;
    localparam logic [3:0] CL_JCOND   = 4'd5;
    localparam logic [3:0] CL_SCOND   = 4'd6;
    localparam logic [3:0] CL_BCOND   = 4'd7;
    localparam logic [3:0] CL_ROM     = 4'd8;
    localparam logic [3:0] CL_NOP     = 4'd9;

    // Map an instruction word onto its class; unlisted op 0100 extensions do nothing.
    function automatic logic [3:0] classify(input logic [DATAW-1:0] w);
        logic [3:0] op;
        logic [3:0] ext;
        logic [3:0] cls;
        op  = w[15:12];
        ext = w[7:4];
        case (op)
            4'b0000: cls = CL_ALU_REG;
            4'b0100: begin
                case (ext)
                    4'b0000: cls = CL_LOAD;
                    4'b0100: cls = CL_STOR;
                    4'b1000: cls = CL_JAL;
                    4'b1100: cls = CL_JCOND;
                    4'b1101: cls = CL_SCOND;
                    default: cls = CL_NOP;
                endcase
            end
            4'b1100: cls = CL_BCOND;
            4'b1111: cls = CL_ROM;
            default: cls = CL_ALU_IMM;
        endcase
        return cls;
    endfunction

    // Evaluate a condition code against flags ordered {N,Z,F,L,C}.
    function automatic logic cond_eval(input logic [3:0] code, input logic [PSRW-1:0] f);
        logic n_f, z_f, f_f, l_f, c_f, res;
        n_f = f[4];
        z_f = f[3];
        f_f = f[2];
        l_f = f[1];
        c_f = f[0];
        case (code)
            4'd0:    res = z_f;
            4'd1:    res = !z_f;
            4'd2:    res = c_f;
            4'd3:    res = !c_f;
            4'd4:    res = n_f;
            4'd5:    res = !n_f;
            4'd6:    res = f_f;
            4'd7:    res = !f_f;
            4'd8:    res = !l_f && !z_f;
            4'd9:    res = l_f || z_f;
            4'd14:   res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [2:0]        state_r;
    logic [2:0]        next_state_s;
    logic [DATAW-1:0]  ir_r;
    logic [PSRW-1:0]   flags_r;

    logic [3:0]        ir_class_s;
    logic [3:0]        fetch_class_s;
    logic              is_mem_s;
    logic              is_alu_s;
    logic              writes_s;
    logic              cond_s;
    logic              takes_pc_s;
    logic [1:0]        wb_mux_s;
    logic              enter_wb_s;

    logic              write_r;
    logic              imm_mux_r;
    logic              cond_rslt_r;
    logic              wb_mux0_r;
    logic [1:0]        wb_mux_r;
    logic [REGW-1:0]   rsrc_r;
    logic [REGW-1:0]   rdst_r;
    logic [ALUOPW-1:0] alu_op_r;
    logic [IMMW-1:0]   imm_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic              pc_inc_r;
    logic              pc_load_r;

    assign ir_class_s    = classify(ir_r);
    assign fetch_class_s = classify(instr);
    assign cond_s        = cond_eval(ir_r[11:8], flags_r);
    assign enter_wb_s    = (next_state_s == S_WB);

    // Per-instruction attributes derived from the latched instruction.
    always_comb begin
        is_mem_s   = (ir_class_s == CL_LOAD) || (ir_class_s == CL_STOR);
        is_alu_s   = (ir_class_s == CL_ALU_REG) || (ir_class_s == CL_ALU_IMM);
        writes_s   = is_alu_s || (ir_class_s == CL_LOAD) || (ir_class_s == CL_JAL) ||
                     (ir_class_s == CL_SCOND) || (ir_class_s == CL_ROM);
        takes_pc_s = (ir_class_s == CL_JAL) ||
                     (((ir_class_s == CL_JCOND) || (ir_class_s == CL_BCOND)) && cond_s);
        case (ir_class_s)
            CL_LOAD:    wb_mux_s = 2'd3;
            CL_SCOND:   wb_mux_s = 2'd1;
            CL_JAL:     wb_mux_s = 2'd0;
            CL_ALU_REG: wb_mux_s = 2'd2;
            CL_ALU_IMM: wb_mux_s = 2'd2;
            default:    wb_mux_s = 2'd0;
        endcase
    end

    // Next-state logic; MEM waits on mem_ack with no timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH:  next_state_s = S_DECODE;
            S_DECODE: next_state_s = S_EXEC;
            S_EXEC: begin
                if (is_mem_s) begin
                    next_state_s = S_MEM;
                end else begin
                    next_state_s = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    next_state_s = S_WB;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB:     next_state_s = S_FETCH;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Instruction register loads in FETCH; flags load at the end of an ALU EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_r    <= {DATAW{1'b0}};
            flags_r <= {PSRW{1'b0}};
        end else begin
            if (state_r == S_FETCH) begin
                ir_r <= instr;
            end
            if ((state_r == S_EXEC) && is_alu_s) begin
                flags_r <= psr_in;
            end
        end
    end

    // Field outputs are captured alongside ir so they are valid from DECODE through WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsrc_r    <= {REGW{1'b0}};
            rdst_r    <= {REGW{1'b0}};
            alu_op_r  <= {ALUOPW{1'b0}};
            imm_mux_r <= 1'b0;
            imm_r     <= {IMMW{1'b0}};
        end else if (state_r == S_FETCH) begin
            rsrc_r    <= instr[3:0];
            // Scond writes its result into the register named in the rSrc field.
            rdst_r    <= (fetch_class_s == CL_SCOND) ? instr[3:0] : instr[11:8];
            imm_mux_r <= (fetch_class_s == CL_ALU_IMM);
            imm_r     <= instr[7:0];
            case (fetch_class_s)
                CL_ALU_REG: alu_op_r <= instr[7:4];
                CL_ALU_IMM: alu_op_r <= instr[15:12];
                default:    alu_op_r <= {ALUOPW{1'b0}};
            endcase
        end
    end

    // Write-back, PC and memory handshake controls, registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_r     <= 1'b0;
            pc_inc_r    <= 1'b0;
            pc_load_r   <= 1'b0;
            wb_mux_r    <= 2'd0;
            wb_mux0_r   <= 1'b0;
            cond_rslt_r <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
        end else begin
            write_r     <= enter_wb_s && writes_s;
            pc_load_r   <= enter_wb_s && takes_pc_s;
            pc_inc_r    <= enter_wb_s && !takes_pc_s;
            wb_mux_r    <= enter_wb_s ? wb_mux_s : 2'd0;
            wb_mux0_r   <= enter_wb_s && (ir_class_s == CL_ROM);
            cond_rslt_r <= enter_wb_s && (ir_class_s == CL_SCOND) && cond_s;
            mem_req_r   <= (next_state_s == S_MEM);
            mem_we_r    <= (next_state_s == S_MEM) && (ir_class_s == CL_STOR);
        end
    end

    assign write     = write_r;
    assign IMM_MUX   = imm_mux_r;
    assign COND_RSLT = cond_rslt_r;
    assign WB_MUX0   = wb_mux0_r;
    assign WB_MUX    = wb_mux_r;
    assign rSrc      = rsrc_r;
    assign rDst      = rdst_r;
    assign aluOp     = alu_op_r;
    assign imm_out   = imm_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign pc_inc    = pc_inc_r;
    assign pc_load   = pc_load_r;

endmodule
